// File: rtl/traffic_pkg.sv
// Shared types, colour codes, default phase durations and helpers for the intersection sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package traffic_pkg;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        RED1     = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        RED2     = 3'd5,
        FLASH    = 3'd6
    } state_t;

    // One light is {B,G,R}; yellow is red plus green, blue never lit.
    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b011;
    localparam logic [2:0] OFF    = 3'b000;

    localparam int DEF_GREEN_TIME   = 20;
    localparam int DEF_YELLOW_TIME  = 4;
    localparam int DEF_ALL_RED_TIME = 2;
    localparam int DEF_PED_CUT      = 5;

    // Integer 0..99 to two packed BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = 8'(v / 10);
        ones = 8'(v % 10);
        return {tens[3:0], ones[3:0]};
    endfunction

    // Fixed sequencing order of the normal cycle; FLASH never advances by tick.
    function automatic state_t next_phase(input state_t s);
        case (s)
            A_GREEN:  return A_YELLOW;
            A_YELLOW: return RED1;
            RED1:     return B_GREEN;
            B_GREEN:  return B_YELLOW;
            B_YELLOW: return RED2;
            RED2:     return A_GREEN;
            default:  return RED2;
        endcase
    endfunction

    // LED pattern {light B, light A} for a state; blink only matters in FLASH.
    function automatic logic [5:0] rgb_of(input state_t s, input logic blink);
        case (s)
            A_GREEN:  return {RED, GREEN};
            A_YELLOW: return {RED, YELLOW};
            RED1:     return {RED, RED};
            B_GREEN:  return {GREEN, RED};
            B_YELLOW: return {YELLOW, RED};
            RED2:     return {RED, RED};
            default:  return blink ? {YELLOW, YELLOW} : {OFF, OFF};
        endcase
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter holding the remaining seconds of the current phase.
// Latency: load/dec take effect on the next rising edge; load wins over dec.
// Backpressure: none; controls are sampled every cycle.
module bcd_down_counter #(
    parameter logic [7:0] RESET_VAL = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_vld,
    input  logic [7:0] load_dat,
    input  logic       dec,
    output logic [7:0] cnt,
    output logic       is_one
);

    // Reset, then load, then a BCD decrement that borrows from tens when ones is 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RESET_VAL;
        end else if (load_vld) begin
            cnt <= load_dat;
        end else if (dec) begin
            if (cnt[3:0] == 4'd0) begin
                cnt <= {cnt[7:4] - 4'd1, 4'd9};
            end else begin
                cnt <= {cnt[7:4], cnt[3:0] - 4'd1};
            end
        end
    end

    assign is_one = (cnt == 8'h01);

endmodule

// File: rtl/traffic_light_controller.sv
// Two-way intersection sequencer: phase FSM, BCD countdown, pedestrian latch and flashing mode.
// Latency: every output is registered, 1 cycle after tick/SW/PED_BTN is sampled.
// Backpressure: none; tick, SW and PED_BTN are sampled every cycle and never stalled.
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_TIME   = DEF_GREEN_TIME,
    parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int PED_CUT      = DEF_PED_CUT
) (
    input  logic       inputCLK,
    input  logic       resetN,
    input  logic       tick,
    input  logic       SW,
    input  logic       PED_BTN,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic [5:0] RGB_LED,
    output logic       PED_PENDING
);

    localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_TIME);
    localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_TIME);
    localparam logic [7:0] RED_BCD    = to_bcd(ALL_RED_TIME);
    localparam logic [7:0] PED_BCD    = to_bcd(PED_CUT);

    state_t     state;
    state_t     state_nxt;
    logic       blink;
    logic       blink_nxt;
    logic       ped_pending;
    logic [5:0] rgb;
    logic       cnt_load_vld;
    logic [7:0] cnt_load_dat;
    logic       cnt_dec;
    logic [7:0] cnt;
    logic       cnt_is_one;

    function automatic logic [7:0] dur_of(input state_t s);
        case (s)
            A_GREEN, B_GREEN:   return GREEN_BCD;
            A_YELLOW, B_YELLOW: return YELLOW_BCD;
            RED1, RED2:         return RED_BCD;
            default:            return 8'h00;
        endcase
    endfunction

    bcd_down_counter #(
        .RESET_VAL(GREEN_BCD)
    ) u_cnt (
        .clk      (inputCLK),
        .rst_n    (resetN),
        .load_vld (cnt_load_vld),
        .load_dat (cnt_load_dat),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .is_one   (cnt_is_one)
    );

    // Next state and counter controls; priority is flash entry, flash exit, phase end, truncation, decrement.
    always_comb begin
        state_nxt    = state;
        blink_nxt    = blink;
        cnt_load_vld = 1'b0;
        cnt_load_dat = 8'h00;
        cnt_dec      = 1'b0;
        if (state != FLASH && !SW) begin
            state_nxt    = FLASH;
            blink_nxt    = 1'b1;
            cnt_load_vld = 1'b1;
            cnt_load_dat = 8'h00;
        end else if (state == FLASH) begin
            if (SW) begin
                state_nxt    = RED2;
                blink_nxt    = 1'b1;
                cnt_load_vld = 1'b1;
                cnt_load_dat = RED_BCD;
            end else if (tick) begin
                blink_nxt = !blink;
            end
        end else if (tick && cnt_is_one) begin
            state_nxt    = next_phase(state);
            cnt_load_vld = 1'b1;
            cnt_load_dat = dur_of(next_phase(state));
        end else if (state == B_GREEN && (ped_pending || PED_BTN) && cnt > PED_BCD) begin
            // A press seen this cycle truncates immediately, so count and latch show together.
            cnt_load_vld = 1'b1;
            cnt_load_dat = PED_BCD;
        end else if (tick) begin
            cnt_dec = 1'b1;
        end
    end

    // Phase FSM with registered lights and pedestrian latch; latch is cleared in A_GREEN and FLASH.
    always_ff @(posedge inputCLK) begin
        if (!resetN) begin
            state       <= A_GREEN;
            blink       <= 1'b1;
            ped_pending <= 1'b0;
            rgb         <= rgb_of(A_GREEN, 1'b1);
        end else begin
            state       <= state_nxt;
            blink       <= blink_nxt;
            ped_pending <= (state_nxt == A_GREEN || state_nxt == FLASH) ? 1'b0
                                                                       : (ped_pending | PED_BTN);
            rgb         <= rgb_of(state_nxt, blink_nxt);
        end
    end

    assign Q           = cnt[3:0];
    assign R           = cnt[7:4];
    assign RGB_LED     = rgb;
    assign PED_PENDING = ped_pending;

endmodule
